// File: rtl/fp_cvt_d2i_pipe.sv
// fp_cvt_d2i_pipe: two-stage binary64 -> INT_W-bit integer converter (FCVT.W/WU/L/LU.D) with valid/ready flow.
// Build option FCVT_STATS_EN adds saturating NV/NX event counters and their clear input.
module fp_cvt_d2i_pipe #(
    parameter int INT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_d,
    input  logic             in_signed,
    input  logic [2:0]       in_rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_int,
    output logic             out_nv,
    output logic             out_nx
`ifdef FCVT_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_nv_cnt,
    output logic [CNT_W-1:0] stat_nx_cnt
`endif
);

    localparam int IW = INT_W + 2;
    localparam int XW = IW + 53;
    localparam logic signed [12:0] EXP_MAX = 13'(INT_W);

    if ((INT_W != 32 && INT_W != 64) || CNT_W < 1) begin : g_bad_cfg
        $error("fp_cvt_d2i_pipe: INT_W must be 32 or 64 and CNT_W positive");
    end

    typedef struct packed {
        logic             nv;
        logic [INT_W-1:0] val;
    } sat_t;

    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic lsb, input logic g, input logic s);
        logic inc;
        inc = 1'b0;
        case (rm)
            3'b000:  inc = g & (s | lsb);
            3'b010:  inc = sign & (g | s);
            3'b011:  inc = ~sign & (g | s);
            3'b100:  inc = g;
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

    function automatic sat_t saturate(input logic sign, input logic nan, input logic ovf,
                                      input logic is_signed, input logic [IW-1:0] mag);
        sat_t r;
        logic [INT_W-1:0] smax;
        logic [INT_W-1:0] smin;
        logic [INT_W-1:0] umax;
        logic signed [INT_W-1:0] neg_val;
        smax    = {1'b0, {(INT_W-1){1'b1}}};
        smin    = {1'b1, {(INT_W-1){1'b0}}};
        umax    = '1;
        neg_val = -$signed(mag[INT_W-1:0]);
        r.nv    = 1'b0;
        r.val   = '0;
        if (nan) begin
            r.nv  = 1'b1;
            r.val = is_signed ? smax : umax;
        end else if (ovf) begin
            r.nv  = 1'b1;
            r.val = sign ? (is_signed ? smin : '0) : (is_signed ? smax : umax);
        end else if (!sign) begin
            if (is_signed && mag > {2'b00, smax}) begin
                r.nv  = 1'b1;
                r.val = smax;
            end else if (!is_signed && mag[IW-1:INT_W] != '0) begin
                r.nv  = 1'b1;
                r.val = umax;
            end else begin
                r.val = mag[INT_W-1:0];
            end
        end else begin
            // Negative: a magnitude of 0 after rounding is legal for both targets.
            if (is_signed && mag > {2'b00, smin}) begin
                r.nv  = 1'b1;
                r.val = smin;
            end else if (is_signed) begin
                r.val = neg_val;
            end else if (mag != '0) begin
                r.nv  = 1'b1;
                r.val = '0;
            end
        end
        return r;
    endfunction

    // ---- stage 0: decode and align the incoming operand ----
    logic                sign_p0;
    logic [10:0]         bexp_p0;
    logic [51:0]         frac_p0;
    logic signed [12:0]  uexp_p0;
    logic                normal_p0, nan_p0, inf_p0, big_p0, tiny_p0, aligned_ok_p0;
    logic [6:0]          sh_p0;
    logic [XW-1:0]       aligned_p0;
    logic [IW-1:0]       int_p0;
    logic                g_p0, s_p0;

    assign sign_p0   = in_d[63];
    assign bexp_p0   = in_d[62:52];
    assign frac_p0   = in_d[51:0];
    assign uexp_p0   = $signed({2'b00, bexp_p0}) - 13'sd1023;
    assign normal_p0 = (bexp_p0 != 11'h000) && (bexp_p0 != 11'h7FF);
    assign nan_p0    = (bexp_p0 == 11'h7FF) && (frac_p0 != '0);
    assign inf_p0    = (bexp_p0 == 11'h7FF) && (frac_p0 == '0);
    assign big_p0    = normal_p0 && (uexp_p0 > EXP_MAX);
    assign tiny_p0   = (normal_p0 && (uexp_p0 < -13'sd1)) || ((bexp_p0 == 11'h000) && (frac_p0 != '0));
    assign aligned_ok_p0 = normal_p0 && (uexp_p0 >= -13'sd1) && (uexp_p0 <= EXP_MAX);

    always_comb begin
        sh_p0  = '0;
        int_p0 = '0;
        g_p0   = 1'b0;
        s_p0   = 1'b0;
        // One extra fraction bit below the hidden bit lets exp = -1 land in the guard position.
        if (aligned_ok_p0) begin
            sh_p0 = 7'(uexp_p0 + 13'sd1);
        end
        aligned_p0 = {{IW{1'b0}}, 1'b1, frac_p0} << sh_p0;
        if (aligned_ok_p0) begin
            int_p0 = aligned_p0[53 +: IW];
            g_p0   = aligned_p0[52];
            s_p0   = |aligned_p0[51:0];
        end else if (tiny_p0) begin
            s_p0   = 1'b1;
        end
    end

    // ---- stage 1 registers: classified and aligned operand ----
    logic          vld_p1, vld_p2, s2_adv;
    logic          sign_p1, nan_p1, ovf_p1, signed_p1, g_p1, s_p1;
    logic [2:0]    rm_p1;
    logic [IW-1:0] int_p1;

    assign s2_adv   = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s2_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            sign_p1   <= sign_p0;
            nan_p1    <= nan_p0;
            ovf_p1    <= inf_p0 || big_p0;
            signed_p1 <= in_signed;
            rm_p1     <= in_rm;
            int_p1    <= int_p0;
            g_p1      <= g_p0;
            s_p1      <= s_p0;
        end
    end

    // ---- stage 1 -> 2: round, negate, saturate ----
    logic [IW-1:0] mag_p1;
    sat_t          sat_p1;
    logic          nx_p1;

    assign mag_p1 = int_p1 + IW'(round_inc(rm_p1, sign_p1, int_p1[0], g_p1, s_p1));
    assign sat_p1 = saturate(sign_p1, nan_p1, ovf_p1, signed_p1, mag_p1);
    assign nx_p1  = (g_p1 | s_p1) & ~sat_p1.nv;

    // ---- stage 2 registers: presented result ----
    logic [INT_W-1:0] int_p2;
    logic             nv_p2, nx_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            int_p2 <= '0;
            nv_p2  <= 1'b0;
            nx_p2  <= 1'b0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                int_p2 <= sat_p1.val;
                nv_p2  <= sat_p1.nv;
                nx_p2  <= nx_p1;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_int   = int_p2;
    assign out_nv    = nv_p2;
    assign out_nx    = nx_p2;

`ifdef FCVT_STATS_EN
    logic fire_p2;
    assign fire_p2 = vld_p2 && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_nv_cnt <= '0;
            stat_nx_cnt <= '0;
        end else begin
            if (fire_p2 && nv_p2 && !(&stat_nv_cnt)) stat_nv_cnt <= stat_nv_cnt + CNT_W'(1);
            if (fire_p2 && nx_p2 && !(&stat_nx_cnt)) stat_nx_cnt <= stat_nx_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fp_cvt_d2i_pipe.sv
// Bench for fp_cvt_d2i_pipe: 32- and 64-bit instances share stimulus; a real-arithmetic model scores every result.
module tb_fp_cvt_d2i_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_signed = 1'b0;
    logic [2:0]  in_rm = 3'd0;
    logic [63:0] in_d = 64'd0;
    logic        out_ready = 1'b1;

    logic        rdy32, vld32, nv32, nx32;
    logic [31:0] int32;
    logic        rdy64, vld64, nv64, nx64;
    logic [63:0] int64;

    int total = 0;
    int bad   = 0;
    int n_out32 = 0;
    int n_out64 = 0;

    typedef struct {
        logic [63:0] res;
        logic        nv;
        logic        nx;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    fp_cvt_d2i_pipe #(.INT_W(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .in_d(in_d),
        .in_signed(in_signed), .in_rm(in_rm), .out_valid(vld32), .out_ready(out_ready),
        .out_int(int32), .out_nv(nv32), .out_nx(nx32)
    );

    fp_cvt_d2i_pipe #(.INT_W(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .in_d(in_d),
        .in_signed(in_signed), .in_rm(in_rm), .out_valid(vld64), .out_ready(out_ready),
        .out_int(int64), .out_nv(nv64), .out_nx(nx64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic logic [63:0] r2u(input real m);
        if (m >= 9223372036854775808.0)
            return {1'b1, 63'(longint'(m - 9223372036854775808.0))};
        return 64'(longint'(m));
    endfunction

    // Reference: exact real arithmetic on the operand value, then range rules.
    function automatic void model(input logic [63:0] d, input logic sgn, input logic [2:0] rm,
                                  input int w, output logic [63:0] res, output logic nv,
                                  output logic nx);
        real x, a, fl, fr, m, pw1, pw;
        logic neg, inexact, up;
        logic [63:0] smax, smin, umax;
        pw1 = 1.0;
        for (int i = 0; i < w - 1; i++) pw1 = pw1 * 2.0;
        pw   = pw1 * 2.0;
        umax = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        smax = (64'd1 << (w - 1)) - 64'd1;
        smin = 64'd1 << (w - 1);
        res = 64'd0; nv = 1'b0; nx = 1'b0; up = 1'b0;
        if (d[62:52] == 11'h7FF) begin
            nv = 1'b1;
            if (d[51:0] != 52'd0 || !d[63]) res = sgn ? smax : umax;
            else                            res = sgn ? smin : 64'd0;
            return;
        end
        x  = $bitstoreal(d);
        neg = d[63];
        a  = neg ? -x : x;
        fl = $floor(a);
        fr = a - fl;
        inexact = (fr != 0.0);
        case (rm)
            3'd0: up = (fr > 0.5) || (fr == 0.5 && ($floor(fl / 2.0) * 2.0 != fl));
            3'd2: up = neg && inexact;
            3'd3: up = !neg && inexact;
            3'd4: up = (fr >= 0.5);
            default: up = 1'b0;
        endcase
        m = fl + (up ? 1.0 : 0.0);
        if (sgn) begin
            if (!neg && m >= pw1)     begin nv = 1'b1; res = smax; end
            else if (neg && m > pw1)  begin nv = 1'b1; res = smin; end
            else                      res = neg ? -r2u(m) : r2u(m);
        end else begin
            if (!neg && m >= pw)          begin nv = 1'b1; res = umax; end
            else if (neg && m != 0.0)     begin nv = 1'b1; res = 64'd0; end
            else                          res = r2u(m);
        end
        res = res & umax;
        nx  = inexact && !nv;
    endfunction

    // Scoreboard / protocol checker, sampled on the falling edge.
    logic        stall32 = 1'b0, stall64 = 1'b0;
    logic [33:0] held32 = '0;
    logic [65:0] held64 = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q32.delete();
            q64.delete();
            stall32 = 1'b0;
            stall64 = 1'b0;
        end else begin
            check("in_ready32", 64'(rdy32), 64'(!(q32.size() == 2 && !out_ready)));
            check("in_ready64", 64'(rdy64), 64'(!(q64.size() == 2 && !out_ready)));
            if (stall32) begin
                check("hold_valid32", 64'(vld32), 64'd1);
                check("hold_data32", 64'({int32, nv32, nx32}), 64'(held32));
            end
            if (stall64) begin
                check("hold_valid64", 64'(vld64), 64'd1);
                check("hold_data64", {int64[61:0], nv64, nx64}, held64[63:0]);
            end
            if (vld32 && out_ready) begin
                n_out32++;
                if (q32.size() == 0) check("spurious32", 64'd1, 64'd0);
                else begin
                    e = q32.pop_front();
                    check("res32", 64'(int32), 64'(e.res[31:0]));
                    check("nv32", 64'(nv32), 64'(e.nv));
                    check("nx32", 64'(nx32), 64'(e.nx));
                end
            end
            if (vld64 && out_ready) begin
                n_out64++;
                if (q64.size() == 0) check("spurious64", 64'd1, 64'd0);
                else begin
                    e = q64.pop_front();
                    check("res64", int64, e.res);
                    check("nv64", 64'(nv64), 64'(e.nv));
                    check("nx64", 64'(nx64), 64'(e.nx));
                end
            end
            stall32 = vld32 && !out_ready;
            held32  = {int32, nv32, nx32};
            stall64 = vld64 && !out_ready;
            held64  = {int64, nv64, nx64};
            if (in_valid && rdy32) begin
                model(in_d, in_signed, in_rm, 32, e.res, e.nv, e.nx);
                q32.push_back(e);
            end
            if (in_valid && rdy64) begin
                model(in_d, in_signed, in_rm, 64, e.res, e.nv, e.nx);
                q64.push_back(e);
            end
        end
    end

    function automatic logic [63:0] gen_op();
        logic [63:0] rr;
        logic [63:0] specials [9];
        int k;
        real x;
        specials = '{64'h0, 64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000,
                     64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h7FF0_0000_0000_0001,
                     64'h0000_0000_0000_0001, 64'h000F_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001};
        rr = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0: return rr;
            1: return specials[$urandom_range(0, 8)];
            2: begin
                k = int'($urandom_range(0, 1 << 20));
                x = real'(k) + 0.5;
                if (rr[63]) x = -x;
                return $realtobits(x);
            end
            default: return {rr[63], 11'(1020 + $urandom_range(0, 70)), rr[51:0]};
        endcase
    endfunction

    task automatic rand_op();
        in_d      = gen_op();
        in_signed = 1'($urandom_range(0, 1));
        in_rm     = 3'($urandom_range(0, 7));
    endtask

    task automatic directed(input string name, input logic [63:0] d, input logic sgn,
                            input logic [2:0] rm, input int w, input logic [63:0] eres,
                            input logic env, input logic enx);
        logic [63:0] mres;
        logic mnv, mnx;
        model(d, sgn, rm, w, mres, mnv, mnx);
        check({name, "_model_res"}, mres, eres);
        check({name, "_model_nv"}, 64'(mnv), 64'(env));
        check({name, "_model_nx"}, 64'(mnx), 64'(enx));
        in_valid = 1'b1; in_d = d; in_signed = sgn; in_rm = rm; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_early"}, 64'(w == 32 ? vld32 : vld64), 64'd0);
        @(posedge clk); #1;
        if (w == 32) begin
            check({name, "_valid"}, 64'(vld32), 64'd1);
            check({name, "_res"}, 64'(int32), 64'(eres[31:0]));
            check({name, "_nv"}, 64'(nv32), 64'(env));
            check({name, "_nx"}, 64'(nx32), 64'(enx));
        end else begin
            check({name, "_valid"}, 64'(vld64), 64'd1);
            check({name, "_res"}, int64, eres);
            check({name, "_nv"}, 64'(nv64), 64'(env));
            check({name, "_nx"}, 64'(nx64), 64'(enx));
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) @(posedge clk);
        @(posedge clk); #1;
        check("drain", 64'(q32.size() + q64.size()), 64'd0);
    endtask

    initial begin
        int before32, before64, sent, c;
        logic acc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid32", 64'(vld32), 64'd0);
        check("rst_int32", 64'(int32), 64'd0);
        check("rst_flags64", 64'({nv64, nx64, vld64}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rdy_after_rst", 64'({rdy32, rdy64}), 64'd3);
        @(posedge clk); #1;

        directed("rne_1p5", 64'h3FF8_0000_0000_0000, 1'b1, 3'd0, 32, 64'd2, 1'b0, 1'b1);
        directed("rne_2p5", 64'h4004_0000_0000_0000, 1'b1, 3'd0, 32, 64'd2, 1'b0, 1'b1);
        directed("rmm_2p5", 64'h4004_0000_0000_0000, 1'b1, 3'd4, 32, 64'd3, 1'b0, 1'b1);
        directed("rdn_m1p5", 64'hBFF8_0000_0000_0000, 1'b1, 3'd2, 32, 64'hFFFF_FFFE, 1'b0, 1'b1);
        directed("u_m0p3", 64'hBFD3_3333_3333_3333, 1'b0, 3'd1, 32, 64'd0, 1'b0, 1'b1);
        directed("u_m1", 64'hBFF0_0000_0000_0000, 1'b0, 3'd0, 32, 64'd0, 1'b1, 1'b0);
        directed("s_2p31", 64'h41E0_0000_0000_0000, 1'b1, 3'd1, 32, 64'h7FFF_FFFF, 1'b1, 1'b0);
        directed("u_2p31", 64'h41E0_0000_0000_0000, 1'b0, 3'd1, 32, 64'h8000_0000, 1'b0, 1'b0);
        directed("s_nan", 64'h7FF8_0000_0000_0000, 1'b1, 3'd0, 32, 64'h7FFF_FFFF, 1'b1, 1'b0);
        directed("u_minf", 64'hFFF0_0000_0000_0000, 1'b0, 3'd0, 32, 64'd0, 1'b1, 1'b0);
        directed("u_umax", 64'h41EF_FFFF_FFE0_0000, 1'b0, 3'd0, 32, 64'hFFFF_FFFF, 1'b0, 1'b0);
        directed("u_umax_rne", 64'h41EF_FFFF_FFF0_0000, 1'b0, 3'd0, 32, 64'hFFFF_FFFF, 1'b1, 1'b0);
        directed("u_sub_rup", 64'h0000_0000_0000_0001, 1'b0, 3'd3, 32, 64'd1, 1'b0, 1'b1);
        directed("s_msub_rdn", 64'h8000_0000_0000_0001, 1'b1, 3'd2, 32, 64'hFFFF_FFFF, 1'b0, 1'b1);
        directed("rsv_rm", 64'h3FF8_0000_0000_0000, 1'b1, 3'd5, 32, 64'd1, 1'b0, 1'b1);
        directed("s64_min", 64'hC3E0_0000_0000_0000, 1'b1, 3'd0, 64, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        directed("s64_ovf", 64'h43E0_0000_0000_0000, 1'b1, 3'd0, 64, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        directed("u64_2p63", 64'h43E0_0000_0000_0000, 1'b0, 3'd0, 64, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        directed("u64_2p64", 64'h43F0_0000_0000_0000, 1'b0, 3'd0, 64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        drain();

        // Eight back-to-back operands under a 2-on/2-off out_ready pattern.
        before32 = n_out32;
        before64 = n_out64;
        sent = 0;
        c = 0;
        rand_op();
        while (sent < 8 && c < 200) begin
            in_valid  = 1'b1;
            out_ready = (c % 4) < 2;
            #2;
            acc = in_valid && rdy32;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                rand_op();
            end
            c++;
        end
        check("stream_sent", 64'(sent), 64'd8);
        drain();
        check("stream_count32", 64'(n_out32 - before32), 64'd8);
        check("stream_count64", 64'(n_out64 - before64), 64'd8);

        acc = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom % 4) != 0;
                rand_op();
            end
            out_ready = ($urandom % 4) != 0;
            #2;
            acc = in_valid && rdy32;
            @(posedge clk); #1;
        end
        drain();

        // Reset with both stages occupied.
        out_ready = 1'b0;
        in_valid = 1'b1; in_d = 64'h7FF8_0000_0000_0000; in_signed = 1'b1; in_rm = 3'd0;
        @(posedge clk); #1;
        in_d = 64'h3FF8_0000_0000_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_full", 64'({vld32, rdy32}), 64'b10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", 64'({vld32, vld64}), 64'd0);
        check("mid_rst_int32", 64'(int32), 64'd0);
        check("mid_rst_int64", int64, 64'd0);
        check("mid_rst_flags", 64'({nv32, nx32, nv64, nx64}), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rdy_after_mid_rst", 64'({rdy32, rdy64}), 64'd3);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_stale", 64'({vld32, vld64}), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit, bad=%0d", bad);
        $fatal(1);
    end

endmodule
